// File: rtl/windower_pkg.sv
// Shared types and helpers for the strided sliding-window generator.
package windower_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Half-width of an odd window: taps on each side of the centre.
    function automatic int pad_of(input int w);
        return (w - 1) / 2;
    endfunction

    // A tap is live only when the sample it holds belongs to the current
    // image: shift index j minus tap position k must land inside 0..n-1.
    function automatic logic tap_mask(input int j, input int k, input int n);
        return ((j - k) >= 0) && ((j - k) <= (n - 1));
    endfunction

endpackage

// File: rtl/windower_strided_shreg.sv
// W-deep sample shift register; exposes its post-shift contents so the
// window can be captured in the same cycle as the shift.
module window_shreg #(
    parameter int NO_CH = 2,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shift_i,
    input  logic                         zero_i,
    input  logic [NO_CH-1:0]             data_i,
    output logic [DEPTH-1:0][NO_CH-1:0]  taps_next_o
);

    logic [DEPTH-1:0][NO_CH-1:0] taps_q;
    logic [DEPTH-1:0][NO_CH-1:0] taps_d;
    // The oldest entry is pushed out on the next shift and never observed.
    logic                        unused_oldest;

    // Contents after one shift: entry 0 takes the new sample (or zero).
    always_comb begin
        taps_d    = taps_q;
        taps_d[0] = zero_i ? '0 : data_i;
        for (int k = 1; k < DEPTH; k++) begin
            taps_d[k] = taps_q[k-1];
        end
    end

    assign taps_next_o   = taps_d;
    assign unused_oldest = ^taps_q[DEPTH-1];

    // Shift register storage, advanced only on shift events.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q <= '0;
        end else if (shift_i) begin
            taps_q <= taps_d;
        end
    end

endmodule

// File: rtl/windower_strided.sv
// Streaming 1-D windower: zero-padded odd windows every STRIDE positions,
// ready/valid on both sides, flush of P zero shifts at each image end.
module windower_strided
    import windower_pkg::*;
#(
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int WINDOW_SIZE   = 3,
    parameter int STRIDE        = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               vld_in,
    output logic                               rdy_in,
    input  logic [NO_CH-1:0]                   data_in,
    output logic                               vld_out,
    input  logic                               rdy_out,
    output logic [WINDOW_SIZE-1:0][NO_CH-1:0]  data_out,
    output logic                               first_out,
    output logic                               last_out
);

    localparam int N  = 1 << LOG2_IMG_SIZE;
    localparam int P  = pad_of(WINDOW_SIZE);
    // j reaches N+P-1 < 2N, so one extra bit over the image index suffices.
    localparam int JW = LOG2_IMG_SIZE + 1;

    state_t                             state_q, state_d;
    logic [JW-1:0]                      j_q, j_d;
    logic                               vld_q, vld_d;
    logic                               first_q, first_d;
    logic                               last_q, last_d;
    logic [WINDOW_SIZE-1:0][NO_CH-1:0]  win_q, win_d;
    logic [WINDOW_SIZE-1:0][NO_CH-1:0]  taps_next;

    logic slot_free;
    logic shift_en;
    logic emit;
    int   j_int;
    int   centre;

    window_shreg #(
        .NO_CH (NO_CH),
        .DEPTH (WINDOW_SIZE)
    ) u_shreg (
        .clk         (clk),
        .rst         (rst),
        .shift_i     (shift_en),
        .zero_i      (state_q == FLUSH),
        .data_i      (data_in),
        .taps_next_o (taps_next)
    );

    // Handshake, shift decision and emit decision for this cycle.
    always_comb begin
        slot_free = !vld_q || rdy_out;
        rdy_in    = (state_q == RUN) && slot_free;
        shift_en  = slot_free && ((state_q == FLUSH) || vld_in);
        j_int     = int'(j_q);
        centre    = j_int - P;
        emit      = shift_en && (j_int >= P) && ((centre % STRIDE) == 0);
    end

    // Next state and shift index: RUN consumes N samples, FLUSH injects P zeros.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        if (shift_en) begin
            if (state_q == RUN) begin
                if (j_q == JW'(N - 1)) begin
                    if (P > 0) begin
                        state_d = FLUSH;
                        j_d     = JW'(N);
                    end else begin
                        j_d = '0;
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end else begin
                if (j_q == JW'(N + P - 1)) begin
                    state_d = RUN;
                    j_d     = '0;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
        end
    end

    // Output slot: capture a masked window on emitting shifts, hold while stalled.
    always_comb begin
        vld_d   = vld_q;
        win_d   = win_q;
        first_d = first_q;
        last_d  = last_q;
        if (slot_free) begin
            vld_d = emit;
            if (emit) begin
                for (int k = 0; k < WINDOW_SIZE; k++) begin
                    win_d[k] = tap_mask(j_int, k, N) ? taps_next[k] : '0;
                end
                first_d = (centre == 0);
                last_d  = (centre == N - STRIDE);
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            j_q     <= '0;
            vld_q   <= 1'b0;
            win_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            vld_q   <= vld_d;
            win_q   <= win_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign vld_out   = vld_q;
    assign data_out  = win_q;
    assign first_out = first_q;
    assign last_out  = last_q;

endmodule

// File: tb/tb_windower_strided.sv
// Bench for windower_strided: three configurations (W/S = 3/1, 5/2, 1/4,
// N = 8) each with its own driver, reference model and scoreboard monitor.
module tb_windower_strided;

    localparam int N  = 8;
    localparam int DW = 8;

    logic clk;
    int   checks;
    int   failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int g, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d got=%0h want=%0h", name, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W  = (g == 0) ? 3 : (g == 1) ? 5 : 1;
        localparam int S  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int P  = (W - 1) / 2;
        localparam int NW = N / S;

        typedef struct packed {
            logic [W-1:0][DW-1:0] d;
            logic                 f;
            logic                 l;
        } win_t;

        logic                  rst, vld_in, rdy_in, vld_out, rdy_out;
        logic                  first_out, last_out;
        logic [DW-1:0]         data_in;
        logic [W-1:0][DW-1:0]  data_out;

        win_t          expq[$];
        logic [DW-1:0] img[N];
        int            idx;
        int            popped;
        int            stall_left;
        bit            rnd_rdy;
        bit            done;

        windower_strided #(
            .NO_CH         (DW),
            .LOG2_IMG_SIZE (3),
            .WINDOW_SIZE   (W),
            .STRIDE        (S)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .vld_in    (vld_in),
            .rdy_in    (rdy_in),
            .data_in   (data_in),
            .vld_out   (vld_out),
            .rdy_out   (rdy_out),
            .data_out  (data_out),
            .first_out (first_out),
            .last_out  (last_out)
        );

        // Reference window centred on c, built straight from the image array.
        function automatic win_t make_win(input int c);
            win_t w;
            for (int k = 0; k < W; k++) begin
                int t;
                t = c + P - k;
                w.d[k] = (t >= 0 && t < N) ? img[t] : '0;
            end
            w.f = (c == 0);
            w.l = (c == N - S);
            return w;
        endfunction

        // Record an accepted sample; queue every window it completes.
        task automatic accept(input logic [DW-1:0] x);
            img[idx] = x;
            for (int c = 0; c < N; c += S) begin
                if (c + P == idx || (idx == N - 1 && c + P > N - 1))
                    expq.push_back(make_win(c));
            end
            idx = (idx == N - 1) ? 0 : idx + 1;
        endtask

        function automatic bit pick_rdy();
            if (stall_left > 0) begin
                stall_left--;
                return 1'b0;
            end
            if (rnd_rdy) return ($urandom_range(0, 3) != 0);
            return 1'b1;
        endfunction

        task automatic step(input bit v, input logic [DW-1:0] x, input bit ro,
                            output bit acc);
            vld_in  = v;
            data_in = x;
            rdy_out = ro;
            @(negedge clk);
            acc = v && rdy_in;
            if (acc) accept(x);
            @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [DW-1:0] x, output int stalls);
            bit acc;
            int n;
            acc    = 1'b0;
            n      = 0;
            stalls = 0;
            while (!acc && n < 200) begin
                step(1'b1, x, pick_rdy(), acc);
                if (!acc) stalls++;
                n++;
            end
            if (!acc) chk("send_timeout", g, 64'(n), 64'(0));
        endtask

        task automatic idle(input int cycles);
            bit acc;
            for (int i = 0; i < cycles; i++) step(1'b0, '0, pick_rdy(), acc);
        endtask

        task automatic drain();
            bit acc;
            int n;
            n = 0;
            while ((expq.size() != 0 || vld_out) && n < 100) begin
                step(1'b0, '0, 1'b1, acc);
                n++;
            end
            chk("drain_left", g, 64'(expq.size()), 64'(0));
        endtask

        task automatic do_reset();
            rst     = 1'b1;
            vld_in  = 1'b0;
            data_in = '0;
            rdy_out = 1'b0;
            expq.delete();
            idx = 0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_vld_out", g, 64'(vld_out), 64'(0));
            chk("rst_first_last", g, 64'({first_out, last_out}), 64'(0));
            chk("rst_data_out", g, 64'(data_out), 64'(0));
            chk("rst_rdy_in", g, 64'(rdy_in), 64'(1));
            @(posedge clk);
            #1;
        endtask

        // Driver: directed ramps, mid-image reset, then randomized images.
        initial begin
            int st, tot, base;
            done       = 1'b0;
            stall_left = 0;
            rnd_rdy    = 1'b0;
            do_reset();

            base = popped;
            tot  = 0;
            for (int i = 0; i < 2 * N; i++) begin
                send(DW'((i < N) ? i + 1 : i + 3), st);
                tot += st;
            end
            chk("flush_stalls", g, 64'(tot), 64'(P));
            drain();
            chk("ramp_windows", g, 64'(popped - base), 64'(2 * NW));

            for (int i = 0; i < 5; i++) send(DW'(i + 1), st);
            do_reset();
            base = popped;
            for (int i = 0; i < N; i++) begin
                send(DW'(i + 1), st);
                if (i == 4) stall_left = 3;
            end
            drain();
            chk("post_reset_windows", g, 64'(popped - base), 64'(NW));

            rnd_rdy = 1'b1;
            base    = popped;
            for (int im = 0; im < 6; im++) begin
                for (int i = 0; i < N; i++) begin
                    idle($urandom_range(0, 2));
                    send(DW'($urandom_range(0, 255)), st);
                end
            end
            drain();
            chk("random_windows", g, 64'(popped - base), 64'(6 * NW));
            done = 1'b1;
        end

        // Monitor: compares every transferred window and checks stall holding.
        initial begin
            win_t  e;
            logic [W-1:0][DW-1:0] hd;
            logic  hf, hl;
            bit    holding;
            popped  = 0;
            holding = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    holding = 1'b0;
                end else begin
                    if (holding) begin
                        chk("hold_vld", g, 64'(vld_out), 64'(1));
                        chk("hold_data", g, 64'(data_out), 64'(hd));
                        chk("hold_flags", g, 64'({first_out, last_out}), 64'({hf, hl}));
                    end
                    holding = vld_out && !rdy_out;
                    if (holding) begin
                        hd = data_out;
                        hf = first_out;
                        hl = last_out;
                        chk("rdy_in_stalled", g, 64'(rdy_in), 64'(0));
                    end
                    if (vld_out && rdy_out) begin
                        if (expq.size() == 0) begin
                            chk("unexpected_window", g, 64'(data_out), 64'(0));
                            chk("unexpected_window_cnt", g, 64'(1), 64'(0));
                        end else begin
                            e = expq.pop_front();
                            chk("win_data", g, 64'(data_out), 64'(e.d));
                            chk("win_first", g, 64'(first_out), 64'(e.f));
                            chk("win_last", g, 64'(last_out), 64'(e.l));
                        end
                        popped++;
                    end
                end
            end
        end
    end

    // Wait for all configurations, bounded so the run always ends.
    initial begin
        int cyc;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        while (!(cfg[0].done && cfg[1].done && cfg[2].done) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 50000) begin
            checks++;
            failures++;
            $display("FAIL global_timeout got=%0d want<%0d", cyc, 50000);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
